// File: rtl/approx_adder16_error_monitor.sv
// Error-statistics monitor for 16-bit approximate adders: recomputes the exact sum and
// accumulates error count, error-distance sum and maximum over a window. Optional macro ERR_BIAS_EN adds bias_sum_o.
module approx_adder16_error_monitor #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16,
  parameter int ACC_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  window_i,
  input  logic              valid_i,
  input  logic [WIDTH-1:0]  add1_i,
  input  logic [WIDTH-1:0]  add2_i,
  input  logic [WIDTH:0]    approx_i,
  output logic              ready_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  sample_cnt_o,
  output logic [CNT_W-1:0]  err_cnt_o,
  output logic [ACC_W-1:0]  ed_sum_o,
  output logic [WIDTH:0]    ed_max_o,
`ifdef ERR_BIAS_EN
  output logic signed [ACC_W-1:0] bias_sum_o,
`endif
  output logic [1:0]        state_o
);

  // Handshake: a sample is taken on a rising edge where valid_i && ready_o and start_i is low;
  // ready_o is combinational and high only in RUN.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_e;

  localparam int SUM_W = ((ACC_W > WIDTH + 1) ? ACC_W : WIDTH + 1) + 1;
  localparam logic [SUM_W-1:0] ACC_MAX = SUM_W'({ACC_W{1'b1}});

  state_e             state_q;
  logic               busy_q, done_q;
  logic [CNT_W-1:0]   window_q, acc_cnt_q;
  logic               s1_valid_q;
  logic [WIDTH:0]     s1_exact_q, s1_approx_q;
  logic [CNT_W-1:0]   sample_cnt_q, err_cnt_q;
  logic [ACC_W-1:0]   ed_sum_q, ed_sum_d;
  logic [WIDTH:0]     ed_max_q, ed_max_d, ed;
  logic [SUM_W-1:0]   sum_wide;
  logic               accept, last_accept;

  assign accept      = (state_q == RUN) && valid_i && !start_i;
  assign last_accept = accept && ((acc_cnt_q + CNT_W'(1)) == window_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      window_q  <= '0;
      acc_cnt_q <= '0;
    end else if (start_i) begin
      window_q  <= window_i;
      acc_cnt_q <= '0;
      if (window_i == '0) begin
        state_q <= DONE;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
      end else begin
        state_q <= RUN;
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
      end
    end else begin
      case (state_q)
        RUN: if (accept) begin
          acc_cnt_q <= acc_cnt_q + CNT_W'(1);
          if (last_accept) state_q <= DRAIN;
        end
        DRAIN: begin
          // The last accepted sample commits on this same edge.
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ed       = (s1_exact_q >= s1_approx_q) ? (s1_exact_q - s1_approx_q)
                                           : (s1_approx_q - s1_exact_q);
    sum_wide = SUM_W'(ed_sum_q) + SUM_W'(ed);
    ed_sum_d = (sum_wide > ACC_MAX) ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
    ed_max_d = (ed > ed_max_q) ? ed : ed_max_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || start_i) begin
      s1_valid_q   <= 1'b0;
      s1_exact_q   <= '0;
      s1_approx_q  <= '0;
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      ed_sum_q     <= '0;
      ed_max_q     <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_exact_q  <= {1'b0, add1_i} + {1'b0, add2_i};
        s1_approx_q <= approx_i;
      end
      if (s1_valid_q) begin
        sample_cnt_q <= sample_cnt_q + CNT_W'(1);
        if (ed != '0) err_cnt_q <= err_cnt_q + CNT_W'(1);
        ed_sum_q <= ed_sum_d;
        ed_max_q <= ed_max_d;
      end
    end
  end

`ifdef ERR_BIAS_EN
  localparam int BW = ((ACC_W > WIDTH + 2) ? ACC_W : WIDTH + 2) + 1;
  localparam logic signed [BW-1:0] BIAS_MAX = $signed({{(BW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}});
  localparam logic signed [BW-1:0] BIAS_MIN = ~BIAS_MAX;

  logic signed [ACC_W-1:0] bias_q, bias_d;
  logic signed [WIDTH+1:0] diff;
  logic signed [BW-1:0]    bias_wide;

  always_comb begin
    diff      = $signed({1'b0, s1_approx_q}) - $signed({1'b0, s1_exact_q});
    bias_wide = BW'(bias_q) + BW'(diff);
    if (bias_wide > BIAS_MAX)      bias_d = {1'b0, {(ACC_W-1){1'b1}}};
    else if (bias_wide < BIAS_MIN) bias_d = {1'b1, {(ACC_W-1){1'b0}}};
    else                           bias_d = bias_wide[ACC_W-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || start_i) bias_q <= '0;
    else if (s1_valid_q)  bias_q <= bias_d;
  end

  assign bias_sum_o = bias_q;
`endif

  assign ready_o      = (state_q == RUN);
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign sample_cnt_o = sample_cnt_q;
  assign err_cnt_o    = err_cnt_q;
  assign ed_sum_o     = ed_sum_q;
  assign ed_max_o     = ed_max_q;
  assign state_o      = state_q;

endmodule
